// File: rtl/alu_pkg.sv
// Shared definitions for the registered signed ALU.
//   ALU_WIDTH : default operand/result width
//   alu_op_e  : opcode encoding (ADD, SUB, MUL, SLT)
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 6;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_SLT = 2'b11
    } alu_op_e;

endpackage : alu_pkg

// File: rtl/alu_sat.sv
// Narrows a wide two's-complement value to WIDTH bits and flags overflow.
// Build option: ALU_SATURATE_EN clamps out-of-range values to the signed
// limits; without it the low WIDTH bits are passed through (wrap).
//   val_i : IN_W-bit signed value (IN_W > WIDTH)
//   res_o : WIDTH-bit clamped or wrapped result
//   ovf_o : value lies outside the signed WIDTH-bit range
module alu_sat
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned IN_W  = ALU_WIDTH + 1
) (
    input  logic [IN_W-1:0]  val_i,
    output logic [WIDTH-1:0] res_o,
    output logic             ovf_o
);

    // The value fits iff every bit from the WIDTH-bit sign position upward is equal.
    localparam int unsigned HI_W = IN_W - WIDTH + 1;

    logic [HI_W-1:0] hi_bits;

    assign hi_bits = val_i[IN_W-1:WIDTH-1];
    assign ovf_o   = ~((&hi_bits) | ~(|hi_bits));

`ifdef ALU_SATURATE_EN
    // Clamp toward the sign of the wide value.
    always_comb begin
        res_o = val_i[WIDTH-1:0];
        if (ovf_o) begin
            res_o = val_i[IN_W-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign res_o = val_i[WIDTH-1:0];
`endif

endmodule : alu_sat

// File: rtl/alu.sv
// Registered signed ALU: ADD, SUB, MUL, SLT with one-cycle latency.
// Build option: ALU_SATURATE_EN (see alu_sat) selects clamping on overflow.
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   in_valid  : a/b/op valid this cycle
//   a, b      : WIDTH-bit signed operands
//   op        : opcode (alu_op_e)
//   out       : registered result
//   out_valid : result updated by the previous cycle's in_valid
//   ovf       : signed overflow of the registered operation
//   zero      : registered result equals zero
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned SUM_W  = WIDTH + 1;
    localparam int unsigned PROD_W = 2 * WIDTH;

    logic [SUM_W-1:0]         sum_w;
    logic [SUM_W-1:0]         diff_w;
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;
    logic [PROD_W-1:0]        prod_w;
    logic                     lt;

    logic [WIDTH-1:0] add_res, sub_res, mul_res;
    logic             add_ovf, sub_ovf, mul_ovf;

    logic [WIDTH-1:0] out_q, out_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             valid_q, valid_d;

    // One extra bit holds any add/sub result exactly; 2*WIDTH holds any product.
    assign sum_w  = SUM_W'($signed(a)) + SUM_W'($signed(b));
    assign diff_w = SUM_W'($signed(a)) - SUM_W'($signed(b));
    assign a_ext  = PROD_W'($signed(a));
    assign b_ext  = PROD_W'($signed(b));
    assign prod_w = a_ext * b_ext;
    assign lt     = $signed(a) < $signed(b);

    alu_sat #(.WIDTH(WIDTH), .IN_W(SUM_W)) u_sat_add (
        .val_i (sum_w),
        .res_o (add_res),
        .ovf_o (add_ovf)
    );

    alu_sat #(.WIDTH(WIDTH), .IN_W(SUM_W)) u_sat_sub (
        .val_i (diff_w),
        .res_o (sub_res),
        .ovf_o (sub_ovf)
    );

    alu_sat #(.WIDTH(WIDTH), .IN_W(PROD_W)) u_sat_mul (
        .val_i (prod_w),
        .res_o (mul_res),
        .ovf_o (mul_ovf)
    );

    // Opcode mux; registers hold when no valid input arrives.
    always_comb begin
        out_d   = out_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        valid_d = 1'b0;
        if (in_valid) begin
            valid_d = 1'b1;
            unique case (alu_op_e'(op))
                OP_ADD: begin
                    out_d = add_res;
                    ovf_d = add_ovf;
                end
                OP_SUB: begin
                    out_d = sub_res;
                    ovf_d = sub_ovf;
                end
                OP_MUL: begin
                    out_d = mul_res;
                    ovf_d = mul_ovf;
                end
                OP_SLT: begin
                    out_d = WIDTH'(lt);
                    ovf_d = 1'b0;
                end
                default: begin
                    out_d = out_q;
                    ovf_d = ovf_q;
                end
            endcase
            zero_d = (out_d == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
        end
    end

    assign out       = out_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign out_valid = valid_q;

endmodule : alu

// File: tb/tb_alu.sv
// Directed and random checks of the registered ALU against an integer model.
module tb_alu;

    localparam int unsigned W = 6;

    typedef struct packed {
        logic [W-1:0] res;
        logic         ovf;
        logic         zero;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a, b;
    logic [1:0]   op;
    logic [W-1:0] out;
    logic         out_valid, ovf, zero;

    exp_t sb_q[$];
    exp_t last_exp;
    int   n_cmp = 0;
    int   n_err = 0;

    alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .op        (op),
        .out       (out),
        .out_valid (out_valid),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Reference model using plain integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic [1:0] mop);
        exp_t e;
        int   sa, sb, r;
        logic of;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        case (mop)
            2'b00:   r = sa + sb;
            2'b01:   r = sa - sb;
            2'b10:   r = sa * sb;
            default: r = (sa < sb) ? 1 : 0;
        endcase
        of = (mop != 2'b11) && (r > 31 || r < -32);
        e.res = r[W-1:0];
`ifdef ALU_SATURATE_EN
        if (of) e.res = (r > 31) ? 6'd31 : 6'h20;
`endif
        e.ovf  = of;
        e.zero = (e.res == '0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge: compare the oldest expected result.
    task automatic pop_check(input string tag);
        exp_t e;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        if (sb_q.size() == 0) begin
            chk({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            last_exp = e;
            chk({tag, ".out"},  32'(out),  32'(e.res));
            chk({tag, ".ovf"},  32'(ovf),  32'(e.ovf));
            chk({tag, ".zero"}, 32'(zero), 32'(e.zero));
        end
    endtask

    // Drive one operation, clock it in, check it on the following phase.
    task automatic issue(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic [1:0] top);
        a        = ta;
        b        = tb;
        op       = top;
        in_valid = 1'b1;
        sb_q.push_back(model(ta, tb, top));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        pop_check(tag);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, ".out"},       32'(out),       32'd0);
        chk({tag, ".ovf"},       32'(ovf),       32'd0);
        chk({tag, ".zero"},      32'(zero),      32'd0);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        op       = 2'b00;
        #12;
        chk_cleared("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle.out_valid", 32'(out_valid), 32'd0);

        // Directed cases, issued back to back.
        issue("add_m5_20",   6'b111011, 6'd20, 2'b00);
        chk("add_m5_20.const", 32'(out), 32'b001111);
        issue("sub_5_10",    6'd5,  6'd10, 2'b01);
        chk("sub_5_10.const", 32'(out), 32'b111011);
        issue("sub_3_2",     6'd3,  6'd2,  2'b01);
        issue("mul_5_20",    6'd5,  6'd20, 2'b10);
        chk("mul_5_20.ovf_const", 32'(ovf), 32'd1);
        issue("slt_m3_m10",  6'(-3),  6'(-10), 2'b11);
        chk("slt_m3_m10.zero_const", 32'(zero), 32'd1);
        issue("slt_m10_m3",  6'(-10), 6'(-3),  2'b11);
        issue("add_31_1",    6'd31, 6'd1, 2'b00);
        issue("sub_m32_1",   6'h20, 6'd1, 2'b01);
        issue("add_m32_m1",  6'h20, 6'h3f, 2'b00);
        issue("mul_m32_m32", 6'h20, 6'h20, 2'b10);
        issue("mul_m4_8",    6'(-4), 6'd8, 2'b10);
        issue("sub_0_0",     6'd0, 6'd0, 2'b01);
        issue("slt_eq",      6'd7, 6'd7, 2'b11);

        // Random operations, back to back.
        for (int i = 0; i < 24; i++) begin
            issue("rand", 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                  2'($urandom_range(0, 3)));
        end

        // Hold: inputs change while in_valid is low.
        issue("pre_hold", 6'd31, 6'd1, 2'b00);
        for (int i = 0; i < 2; i++) begin
            a  = 6'($urandom_range(0, 63));
            b  = 6'($urandom_range(0, 63));
            op = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
            chk("hold.out",       32'(out),       32'(last_exp.res));
            chk("hold.ovf",       32'(ovf),       32'(last_exp.ovf));
            chk("hold.zero",      32'(zero),      32'(last_exp.zero));
            chk("hold.out_valid", 32'(out_valid), 32'd0);
        end

        // Asynchronous reset while a result is valid.
        issue("pre_rst", 6'd5, 6'd20, 2'b10);
        #2;
        rst = 1'b1;
        #1;
        chk_cleared("async_rst");

        // Input offered during reset must be discarded.
        a        = 6'd9;
        b        = 6'd9;
        op       = 2'b00;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk_cleared("rst_held");
        in_valid = 1'b0;
        rst      = 1'b0;

        // First operation after reset release.
        issue("post_rst", 6'd10, 6'd12, 2'b00);

        // Reset mid-stream with an operation in flight.
        a        = 6'd1;
        b        = 6'd1;
        op       = 2'b00;
        in_valid = 1'b1;
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk_cleared("inflight_rst");
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("after_inflight.out_valid", 32'(out_valid), 32'd0);
        issue("final", 6'(-1), 6'(-1), 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_alu
